// File: rtl/huff_code_gen.sv
`timescale 1ns/1ps
// huff_code_gen: builds a canonical 4-symbol Huffman code table
// from four 8-bit frequencies, one MIN1/MIN2/MERGE pass per merge.
module huff_code_gen (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        START,
  input  logic [31:0] FREQ,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] CODE_TABLE
);

  typedef enum logic [2:0] {
    IDLE, MIN1, MIN2, MERGE, CANON
  } state_t;

  state_t state, state_n;

  logic [9:0] weight [4];
  logic [3:0] mask   [4];
  logic [1:0] depth  [4];
  logic [3:0] active;
  logic [1:0] cnt;
  logic [1:0] sel_a, sel_b;

  logic [1:0] min_a, min_b;
  logic [9:0] wa, wb;
  logic       fa, fb;
  logic [1:0] lo, hi;
  logic [3:0] mm;
  logic [9:0] wsum;
  logic [2:0] code;
  logic [15:0] table_n;

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (START) state_n = MIN1;
      MIN1:    state_n = MIN2;
      MIN2:    state_n = MERGE;
      MERGE:   state_n = (cnt == 2'd2) ? CANON : MIN1;
      CANON:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_a = '0;
    min_b = '0;
    wa    = '0;
    wb    = '0;
    fa    = 1'b0;
    fb    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (active[i] && (!fa || weight[i] < wa)) begin
        fa    = 1'b1;
        wa    = weight[i];
        min_a = 2'(i);
      end
      if (active[i] && (2'(i) != sel_a) &&
          (!fb || weight[i] < wb)) begin
        fb    = 1'b1;
        wb    = weight[i];
        min_b = 2'(i);
      end
    end
  end

  always_comb begin
    lo   = (sel_a < sel_b) ? sel_a : sel_b;
    hi   = (sel_a < sel_b) ? sel_b : sel_a;
    mm   = mask[sel_a] | mask[sel_b];
    wsum = weight[sel_a] + weight[sel_b];
  end

  // Canonical code = sum of 2^(Li-Lj) over symbols ordered before i.
  always_comb begin
    table_n = '0;
    code    = '0;
    for (int i = 0; i < 4; i++) begin
      code = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != i &&
            (depth[j] < depth[i] ||
             (depth[j] == depth[i] && j < i)))
          code = code + (3'd1 << (depth[i] - depth[j]));
      end
      table_n[4*i +: 4] = (4'd1 << depth[i]) | {1'b0, code};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        weight[i] <= '0;
        mask[i]   <= '0;
        depth[i]  <= '0;
      end
      active     <= '0;
      cnt        <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      DONE       <= 1'b0;
      CODE_TABLE <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            for (int i = 0; i < 4; i++) begin
              weight[i] <= {2'b00, FREQ[8*i +: 8]};
              mask[i]   <= 4'(1 << i);
              depth[i]  <= '0;
            end
            active <= 4'hF;
            cnt    <= '0;
          end
        end
        MIN1: sel_a <= min_a;
        MIN2: sel_b <= min_b;
        MERGE: begin
          for (int i = 0; i < 4; i++)
            if (mm[i]) depth[i] <= depth[i] + 2'd1;
          weight[lo] <= wsum;
          mask[lo]   <= mm;
          active[hi] <= 1'b0;
          cnt        <= cnt + 2'd1;
        end
        CANON: begin
          CODE_TABLE <= table_n;
          DONE       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_code_gen.sv
`timescale 1ns/1ps
// tb_huff_code_gen: directed and random checks of huff_code_gen
// against a sort-based canonical Huffman reference model.
module tb_huff_code_gen;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] FREQ = '0;
  logic        BUSY;
  logic        DONE;
  logic [15:0] CODE_TABLE;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_tab = '0;

  huff_code_gen dut (
    .CLK(CLK),
    .nRST(nRST),
    .START(START),
    .FREQ(FREQ),
    .BUSY(BUSY),
    .DONE(DONE),
    .CODE_TABLE(CODE_TABLE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] f);
    int wt[4];
    int grp[4];
    bit act[4];
    int len[4];
    int ord[4];
    int a, b, lo, hi, s, g, tmp, c;
    logic [15:0] t;
    for (int i = 0; i < 4; i++) begin
      wt[i]  = int'(f[8*i +: 8]);
      grp[i] = 1 << i;
      act[i] = 1'b1;
      len[i] = 0;
      ord[i] = i;
    end
    repeat (3) begin
      a = -1;
      b = -1;
      for (int i = 0; i < 4; i++)
        if (act[i] && (a < 0 || wt[i] < wt[a])) a = i;
      for (int i = 0; i < 4; i++)
        if (act[i] && i != a && (b < 0 || wt[i] < wt[b])) b = i;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      s = wt[a] + wt[b];
      g = grp[a] | grp[b];
      for (int k = 0; k < 4; k++)
        if (g[k]) len[k]++;
      wt[lo] = s;
      grp[lo] = g;
      act[hi] = 1'b0;
    end
    for (int p = 0; p < 3; p++)
      for (int q = 0; q < 3 - p; q++)
        if (len[ord[q]] * 4 + ord[q] > len[ord[q+1]] * 4 + ord[q+1]) begin
          tmp = ord[q];
          ord[q] = ord[q+1];
          ord[q+1] = tmp;
        end
    t = '0;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) c = (c + 1) << (len[ord[k]] - len[ord[k-1]]);
      t[4*ord[k] +: 4] = 4'((1 << len[ord[k]]) | c);
    end
    return t;
  endfunction

  task automatic run(input logic [31:0] f,
                     input logic [15:0] exp,
                     input int poke);
    START = 1'b1;
    FREQ  = f;
    @(posedge CLK); #1;
    START = 1'b0;
    FREQ  = ~f;
    chk("busy_e0", 16'(BUSY), 16'd1);
    chk("done_e0", 16'(DONE), 16'd0);
    for (int k = 1; k <= 9; k++) begin
      if (k == poke) begin
        START = 1'b1;
        FREQ  = 32'h01020304;
      end
      @(posedge CLK); #1;
      START = 1'b0;
      chk("code_hold", CODE_TABLE, last_tab);
      chk("busy_run", 16'(BUSY), 16'd1);
      chk("done_run", 16'(DONE), 16'd0);
    end
    @(posedge CLK); #1;
    chk("code", CODE_TABLE, exp);
    chk("done_e10", 16'(DONE), 16'd1);
    chk("busy_e10", 16'(BUSY), 16'd0);
    last_tab = exp;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      chk("idle_done", 16'(DONE), 16'd0);
      chk("idle_busy", 16'(BUSY), 16'd0);
      chk("idle_code", CODE_TABLE, last_tab);
    end
  endtask

  initial begin
    logic [31:0] f;
    logic [7:0]  byt;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_code", CODE_TABLE, 16'h0000);
    chk("rst_busy", 16'(BUSY), 16'd0);
    chk("rst_done", 16'(DONE), 16'd0);
    nRST = 1'b1;
    idle(3);

    run(32'h05_14_32_64, 16'hFE62, 0);
    idle(2);
    run(32'h0A0A0A0A, 16'h7654, 0);
    idle(1);
    run(32'h00000000, 16'h26FE, 0);
    idle(1);

    run(32'h05_14_32_64, 16'hFE62, 3);
    idle(2);
    run(32'h0A0A0A0A, 16'h7654, 0);
    run(32'h0A0A0A0A, 16'h7654, 0);
    idle(2);

    START = 1'b1;
    FREQ  = 32'h05_14_32_64;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("abort_code", CODE_TABLE, 16'h0000);
    chk("abort_busy", 16'(BUSY), 16'd0);
    chk("abort_done", 16'(DONE), 16'd0);
    last_tab = '0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle(12);
    run(32'h05_14_32_64, 16'hFE62, 0);
    idle(1);

    for (int n = 0; n < 25; n++) begin
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 2))
          0: byt = 8'($urandom_range(0, 255));
          1: byt = 8'($urandom_range(0, 3));
          default: byt = 8'hFF;
        endcase
        f[8*b +: 8] = byt;
      end
      run(f, model(f), 0);
      if (n % 3 == 0) idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_code_gen.md
# huff_code_gen

Builds a 4-symbol Huffman code table from four 8-bit symbol frequencies and presents it as a 16-bit packed table. It sits directly upstream of the LED display stage, which consumes `CODE_TABLE` one nibble at a time. A multi-cycle FSM computes the table, which is then held stable until the next computation completes.

## Interface
Parameters: none. The symbol count (4) and the frequency width (8) are fixed.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `START`  in  1  request to build a table; sampled only while idle.
- `FREQ`  in  32  `FREQ[8i+7:8i]` is the frequency of symbol i (i=0..3), unsigned.
- `BUSY`  out  1  high while a computation is in progress.
- `DONE`  out  1  one-cycle pulse when `CODE_TABLE` is updated.
- `CODE_TABLE`  out  16  `CODE_TABLE[4i+3:4i]` is the code of symbol i, sentinel-encoded.

## Operation
- Sentinel encoding: nibble = (1 << L) | code, where L is the code length (1..3) and the code is LSB-aligned.
  - '0' → 0010, '10' → 0110, '110' → 1110, '111' → 1111, '01' → 0101.
- FSM states: IDLE, MIN1, MIN2, MERGE, CANON. MIN1, MIN2 and MERGE run as a group 3 times.
- IDLE with START=1:
  - Load slot i with weight = `FREQ` byte i, zero-extended to 10 bits.
  - Set active[i]=1, group mask[i]=one-hot(i), depth[i]=0.
  - Clear the merge counter and go to MIN1.
- MIN1: register slot a = the active slot with the smallest weight. Ties go to the lower slot index.
- MIN2: register slot b = the smallest active slot other than a, with the same tie rule.
- MERGE:
  - Increment depth of every symbol in mask[a] | mask[b].
  - Slot min(a,b) takes weight[a]+weight[b] and mask[a]|mask[b]; slot max(a,b) becomes inactive.
  - After the 3rd merge go to CANON, otherwise go back to MIN1.
- CANON: assign canonical codes.
  - Order symbols by (depth ascending, symbol index ascending).
  - The first symbol gets code 0 of its length. Each next code = (previous code + 1) << (L_next − L_prev).
  - Register `CODE_TABLE` and go to IDLE.
- Only two length sets can occur: (2,2,2,2) or a permutation of (1,2,3,3). Any implementation giving identical results is acceptable.
- Width: the maximum weight sum is 1020, so 10 bits suffice and overflow cannot occur.
- Zero frequencies are legal and are handled as ordinary weights.
- START while BUSY is ignored. `FREQ` is sampled only on the accepting edge; later changes to `FREQ` have no effect.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `CODE_TABLE`=16'h0000, FSM in IDLE. All internal registers are cleared.
- Edge E0 samples START=1 in IDLE. After E0, `BUSY`=1.
- Edges E1..E9 execute MIN1/MIN2/MERGE three times.
- Edge E10 executes CANON. After E10:
  - `CODE_TABLE` holds the new value.
  - `DONE`=1 for exactly one cycle.
  - `BUSY`=0.
- Latency is 10 clocks from the START-sampling edge to the `CODE_TABLE` update.
- `CODE_TABLE` changes only at CANON and holds its value between completions.
- Back-to-back operation: START sampled in the cycle where `DONE`=1 is accepted, because the FSM is then in IDLE. The next result follows 10 edges later.
- Reset asserted mid-operation:
  - Outputs return to reset values immediately.
  - The partial computation is discarded.
  - No `DONE` is produced.
- A START pulse that is high at the reset-release edge is ignored unless nRST is already high at that edge.

## Test plan
- Reset: hold nRST low, then release → `CODE_TABLE`=16'h0000, `BUSY`=0, `DONE`=0. `DONE` stays low with no START.
- Skewed frequencies: `FREQ`={s3=5, s2=20, s1=50, s0=100} → after 10 clocks, `CODE_TABLE`=16'hFE62 and `DONE` pulses for one cycle.
- All equal: every byte = 10 → `CODE_TABLE`=16'h7654 (lengths 2,2,2,2).
- All zero: `FREQ`=0 → `CODE_TABLE`=16'h26FE, which checks the lower-slot tie rule.
- Handshake, two cases:
  - Pulse START at E0+3 while BUSY, with different `FREQ` → ignored, result unchanged.
  - START during the `DONE` cycle with the all-equal input → second result 16'h7654 exactly 10 clocks later.
- Abort: assert nRST at E0+5 → all outputs zero and no `DONE`. A fresh START then yields a correct table.
